// File: rtl/game_pkg.sv
// Shared types and screen constants for the game-level sequencer.
// Holds the game state encoding, the visible-area limits and the ground pattern length.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } game_state_t;

    localparam logic [8:0] LAST_ROW      = 9'd479;
    localparam logic [9:0] LAST_COL      = 10'd639;
    localparam int         GROUND_PERIOD = 320;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter that saturates at 9999.
// Ports: CLK, rst (async, active-high), clr (sync clear), inc (count enable), value (BCD, [15:12] MSD).
module bcd_counter4
    import game_pkg::*;
(
    input  logic        CLK,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value
);

    logic [15:0] nxt;
    logic        carry;

    // Ripple the +1 through the digits: a digit at 9 rolls to 0 and carries.
    always_comb begin
        nxt   = value;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[i*4 +: 4] == 4'd9) begin
                    nxt[i*4 +: 4] = 4'd0;
                end else begin
                    nxt[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            value <= 16'h0000;
        end else if (clr) begin
            value <= 16'h0000;
        end else if (inc && (value != 16'h9999)) begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/game_scroll_ctrl.sv
// Game sequencer for the scrolling ground: idle/run/dead FSM, per-frame tick,
// scroll offset, speed ramp and BCD score.
// Ports: CLK, rst (async, active-high), row_addr/col_addr (VGA scan position),
// start_btn, collision (levels), game_status (RUN), game_over (DEAD),
// scroll_pos, speed, score (BCD), frame_tick (one-cycle frame-end strobe).
module game_scroll_ctrl
    import game_pkg::*;
#(
    parameter logic [8:0] LAST_ROW      = game_pkg::LAST_ROW,
    parameter logic [9:0] LAST_COL      = game_pkg::LAST_COL,
    parameter int         SCROLL_PERIOD = GROUND_PERIOD,
    parameter int         SPEED_INIT    = 4,
    parameter int         SPEED_MAX     = 8,
    parameter int         RAMP_FRAMES   = 256,
    parameter int         SCORE_DIV     = 8
)(
    input  logic        CLK,
    input  logic        rst,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        start_btn,
    input  logic        collision,
    output logic        game_status,
    output logic        game_over,
    output logic [8:0]  scroll_pos,
    output logic [3:0]  speed,
    output logic [15:0] score,
    output logic        frame_tick
);

    localparam int FW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam int DW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(RAMP_FRAMES - 1);
    localparam logic [DW-1:0] D_LAST = DW'(SCORE_DIV - 1);

    game_state_t   state, state_nx;
    logic          match, match_d;
    logic          start_d, start_rise;
    logic          load, advance;
    logic          frame_wrap, score_inc;
    logic [FW-1:0] frame_cnt;
    logic [DW-1:0] score_div;
    logic [9:0]    sum;

    assign match      = (row_addr == LAST_ROW) && (col_addr == LAST_COL);
    assign start_rise = start_btn && !start_d;
    assign sum        = {1'b0, scroll_pos} + {6'd0, speed};
    assign frame_wrap = (frame_cnt == F_LAST);
    // Collision on the tick cycle suppresses the update.
    assign advance    = (state == RUN) && frame_tick && !collision;
    assign score_inc  = advance && (score_div == D_LAST);

    assign game_status = (state == RUN);
    assign game_over   = (state == DEAD);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Restart has priority in DEAD; collision is only looked at while RUN.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (collision) begin
                    state_nx = DEAD;
                end
            end
            DEAD: begin
                if (start_rise) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            match_d    <= 1'b0;
            start_d    <= 1'b0;
            frame_tick <= 1'b0;
            scroll_pos <= 9'd0;
            speed      <= 4'(SPEED_INIT);
            frame_cnt  <= '0;
            score_div  <= '0;
        end else begin
            match_d    <= match;
            start_d    <= start_btn;
            frame_tick <= match && !match_d;
            if (load) begin
                scroll_pos <= 9'd0;
                speed      <= 4'(SPEED_INIT);
                frame_cnt  <= '0;
                score_div  <= '0;
            end else if (advance) begin
                // speed < period, so one subtract brings the sum back in range.
                if (sum >= 10'(SCROLL_PERIOD)) begin
                    scroll_pos <= 9'(sum - 10'(SCROLL_PERIOD));
                end else begin
                    scroll_pos <= sum[8:0];
                end
                frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
                if (frame_wrap && (speed < 4'(SPEED_MAX))) begin
                    speed <= speed + 4'd1;
                end
                score_div <= (score_div == D_LAST) ? '0 : score_div + 1'b1;
            end
        end
    end

    bcd_counter4 u_score (
        .CLK   (CLK),
        .rst   (rst),
        .clr   (load),
        .inc   (score_inc),
        .value (score)
    );

endmodule

// File: tb/tb_game_scroll_ctrl.sv
// Directed bench for game_scroll_ctrl: default instance plus a SCORE_DIV=1
// instance sharing the same stimulus so score saturation is reachable quickly.
module tb_game_scroll_ctrl;

    logic        CLK = 1'b0;
    logic        rst;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        start_btn;
    logic        collision;

    logic        game_status, game_over, frame_tick;
    logic [8:0]  scroll_pos;
    logic [3:0]  speed;
    logic [15:0] score;

    logic        s_status, s_over, s_tick;
    logic [8:0]  s_pos;
    logic [3:0]  s_speed;
    logic [15:0] s_score;

    int nvec = 0;
    int nerr = 0;
    int ticks;

    always #5 CLK = ~CLK;

    game_scroll_ctrl dut (
        .CLK         (CLK),
        .rst         (rst),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .start_btn   (start_btn),
        .collision   (collision),
        .game_status (game_status),
        .game_over   (game_over),
        .scroll_pos  (scroll_pos),
        .speed       (speed),
        .score       (score),
        .frame_tick  (frame_tick)
    );

    game_scroll_ctrl #(.SCORE_DIV(1)) dut_s (
        .CLK         (CLK),
        .rst         (rst),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .start_btn   (start_btn),
        .collision   (collision),
        .game_status (s_status),
        .game_over   (s_over),
        .scroll_pos  (s_pos),
        .speed       (s_speed),
        .score       (s_score),
        .frame_tick  (s_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic frame();
        row_addr = 9'd479;
        col_addr = 10'd639;
        step();
        row_addr = 9'd0;
        col_addr = 10'd0;
        step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        rst       = 1'b1;
        row_addr  = 9'd0;
        col_addr  = 10'd0;
        start_btn = 1'b0;
        collision = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        chk("rst_status", 32'(game_status), 32'd0);
        chk("rst_over",   32'(game_over),   32'd0);
        chk("rst_pos",    32'(scroll_pos),  32'd0);
        chk("rst_speed",  32'(speed),       32'd4);
        chk("rst_score",  32'(score),       32'h0);
        chk("rst_tick",   32'(frame_tick),  32'd0);

        // Idle: tick still fires; hold match 5 cycles for one tick only.
        row_addr = 9'd479;
        col_addr = 10'd639;
        ticks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            ticks += int'(frame_tick);
        end
        row_addr = 9'd0;
        col_addr = 10'd0;
        step();
        ticks += int'(frame_tick);
        step();
        chk("held_ticks", 32'(ticks), 32'd1);
        chk("idle_pos",   32'(scroll_pos), 32'd0);
        chk("idle_status", 32'(game_status), 32'd0);

        // Start and scroll.
        start_btn = 1'b1;
        step();
        chk("start_status", 32'(game_status), 32'd1);
        start_btn = 1'b0;
        step();
        frames(100);
        chk("f100_pos",   32'(scroll_pos), 32'd80);
        chk("f100_score", 32'(score),      32'h0012);
        chk("f100_speed", 32'(speed),      32'd4);
        chk("f100_sscore", 32'(s_score),   32'h0100);
        frames(59);
        chk("f159_pos", 32'(scroll_pos), 32'd316);
        frames(1);
        chk("f160_pos", 32'(scroll_pos), 32'd0);
        frames(95);
        chk("f255_speed", 32'(speed), 32'd4);
        frames(1);
        chk("f256_speed", 32'(speed), 32'd5);
        chk("f256_pos",   32'(scroll_pos), 32'd64);
        frames(51);
        chk("f307_pos", 32'(scroll_pos), 32'd319);
        frames(1);
        chk("f308_pos", 32'(scroll_pos), 32'd4);
        frames(204);
        chk("f512_speed", 32'(speed), 32'd6);
        chk("f512_pos",   32'(scroll_pos), 32'd64);
        frames(256);
        chk("f768_speed", 32'(speed), 32'd7);
        chk("f768_pos",   32'(scroll_pos), 32'd0);
        frames(256);
        chk("f1024_speed", 32'(speed), 32'd8);
        chk("f1024_pos",   32'(scroll_pos), 32'd192);
        chk("f1024_score", 32'(score), 32'h0128);
        frames(256);
        chk("f1280_speed", 32'(speed), 32'd8);
        chk("f1280_pos",   32'(scroll_pos), 32'd0);
        chk("f1280_score", 32'(score), 32'h0160);
        chk("f1280_sscore", 32'(s_score), 32'h1280);

        // Start edge during RUN is ignored; keep it held through the death.
        start_btn = 1'b1;
        step();
        chk("run_start_ign", 32'(game_status), 32'd1);

        // Collision on the tick cycle: DEAD, no update.
        row_addr = 9'd479;
        col_addr = 10'd639;
        step();
        chk("tick_hi", 32'(frame_tick), 32'd1);
        collision = 1'b1;
        row_addr  = 9'd0;
        col_addr  = 10'd0;
        step();
        chk("coll_over",   32'(game_over),   32'd1);
        chk("coll_status", 32'(game_status), 32'd0);
        chk("coll_pos",    32'(scroll_pos),  32'd0);
        chk("coll_speed",  32'(speed),       32'd8);
        chk("coll_score",  32'(score),       32'h0160);
        collision = 1'b0;
        frames(3);
        chk("dead_held_over", 32'(game_over), 32'd1);
        chk("dead_speed",     32'(speed),     32'd8);
        chk("dead_score",     32'(score),     32'h0160);

        // Restart together with collision: restart wins.
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        collision = 1'b1;
        step();
        chk("rs_status", 32'(game_status), 32'd1);
        chk("rs_pos",    32'(scroll_pos),  32'd0);
        chk("rs_speed",  32'(speed),       32'd4);
        chk("rs_score",  32'(score),       32'h0);
        step();
        chk("rs_coll_over", 32'(game_over), 32'd1);
        collision = 1'b0;
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        chk("rs2_status", 32'(game_status), 32'd1);
        chk("rs2_sscore", 32'(s_score), 32'h0);
        start_btn = 1'b0;

        // Score saturation on the SCORE_DIV=1 instance.
        frames(1000);
        chk("s1000", 32'(s_score), 32'h1000);
        frames(8999);
        chk("s9999", 32'(s_score), 32'h9999);
        frames(17);
        chk("s_sat", 32'(s_score), 32'h9999);
        chk("d10016_score", 32'(score), 32'h1252);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_status", 32'(game_status), 32'd0);
        chk("arst_over",   32'(game_over),   32'd0);
        chk("arst_pos",    32'(scroll_pos),  32'd0);
        chk("arst_speed",  32'(speed),       32'd4);
        chk("arst_score",  32'(score),       32'h0);
        chk("arst_sscore", 32'(s_score),     32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/game_scroll_ctrl.md
# game_scroll_ctrl

Game-level sequencer for the scrolling ground layer. It runs the idle/run/dead game state machine and derives a once-per-frame tick from the VGA scan addresses. Each frame it advances the ground scroll offset, ramps the scroll speed and counts the score. Its outputs drive the ground renderer's `game_status`, scroll offset and speed inputs, and the score display.

## Interface
Parameters:
- `LAST_ROW`, default 9'd479: final visible scan row; part of the frame-end match.
- `LAST_COL`, default 10'd639: final visible scan column; part of the frame-end match.
- `SCROLL_PERIOD`, default 320: ground pattern length in pixels; `scroll_pos` wraps modulo this value.
- `SPEED_INIT`, default 4: speed loaded at start of every run.
- `SPEED_MAX`, default 8: speed ceiling; must be < `SCROLL_PERIOD` and ≤ 15.
- `RAMP_FRAMES`, default 256: frames between speed increments; a power of two.
- `SCORE_DIV`, default 8: frames per score point; a power of two.

Ports:
- `CLK` in 1: system clock; the only clock.
- `rst` in 1: reset; asynchronous, active-high.
- `row_addr` in 9: current VGA scan row.
- `col_addr` in 10: current VGA scan column.
- `start_btn` in 1: start/restart button, already synchronised; level input.
- `collision` in 1: dinosaur/obstacle hit; level input.
- `game_status` out 1: 1 while RUN.
- `game_over` out 1: 1 while DEAD.
- `scroll_pos` out 9: ground offset, 0..SCROLL_PERIOD-1.
- `speed` out 4: pixels advanced per frame.
- `score` out 16: four BCD digits, `[15:12]` is the most significant.
- `frame_tick` out 1: one-cycle frame-end strobe, for other sprites.

## Operation
- **Frame tick**
  - `match` = (`row_addr` == `LAST_ROW`) && (`col_addr` == `LAST_COL`).
  - `frame_tick` = `match` && !`match_d`, where `match_d` is `match` registered.
  - The tick fires once per frame even when the scan address is held for several CLK cycles.
  - The tick fires in every state.
- **Start edge**: `start_rise` = `start_btn` && !`start_d`, using a registered copy of `start_btn`.
- **States**: IDLE, RUN, DEAD.
  - IDLE → RUN on `start_rise`. The transition loads `scroll_pos`=0, `speed`=`SPEED_INIT`, `score`=0, and clears the frame and score counters.
  - RUN → DEAD when `collision`=1, on any cycle, independent of the tick.
  - DEAD → RUN on `start_rise`, with the same loads as IDLE → RUN.
  - No path returns to IDLE except reset.
- **Per tick in RUN** (skipped if `collision`=1 on the same cycle):
  - `sum` = `scroll_pos` + `speed` (10-bit).
  - `scroll_pos` ← `sum` − `SCROLL_PERIOD` if `sum` ≥ `SCROLL_PERIOD`, else `sum`. A single subtract suffices because `speed` < `SCROLL_PERIOD`.
  - The 8-bit frame counter increments. On its wrap to 0, `speed` increments if `speed` < `SPEED_MAX`, otherwise holds.
  - The score divider increments. On its wrap, `score` increments in BCD with digit carry, saturating at 9999.
- **DEAD**: `scroll_pos`, `speed` and `score` freeze at their values from the collision cycle.
- **Outputs**: `game_status` = (state==RUN); `game_over` = (state==DEAD).

## Timing
- **Reset values**: state IDLE, `game_status`=0, `game_over`=0, `scroll_pos`=0, `speed`=`SPEED_INIT`, `score`=0, `frame_tick`=0. All internal counters and edge registers are 0.
- **Latency**
  - `frame_tick` is registered: it is high on the cycle after the first `match` cycle.
  - `scroll_pos`, `speed` and `score` update on the clock edge following the `frame_tick` cycle.
  - State changes take 1 cycle after `start_rise`/`collision` is sampled.
- **Simultaneous events**
  - `collision` wins over a tick: no scroll, speed or score update on that edge.
  - `start_rise` in RUN is ignored.
  - `start_rise` and `collision` together in DEAD: restart wins, the next state is RUN, and collision is evaluated from the following cycle.
- A held `start_btn` does not restart again after a death; a new rising edge is required.
- Asserting `rst` mid-run returns all outputs to their reset values immediately (asynchronously).

## Structure
- Shared package `game_pkg`:
  - state enum `game_state_t` {IDLE, RUN, DEAD};
  - screen constants `LAST_ROW`, `LAST_COL`;
  - `GROUND_PERIOD` = 320.
- Sub-module `bcd_counter4`: increment enable, saturation at 9999, asynchronous active-high reset. It is the only natural split.
- Tick detection, the FSM, the scroll adder and the speed ramp stay in the top level.

## Test plan
- **Reset/idle**: assert `rst` mid-stream and hold it; sweep the scan addresses through a frame → all outputs at reset values, `frame_tick` pulses once per frame, `scroll_pos` stays 0.
- **Start and scroll**: pulse `start_btn`, then run 100 frames → `game_status`=1, `scroll_pos`=(4·100) mod 320 = 80. `score`=0x0012 (100 frames / `SCORE_DIV` 8 = 12 points, BCD "0012").
- **Wrap**: force `scroll_pos`=318 at `speed`=4, then one tick → `scroll_pos`=2.
- **Speed ramp**: run 256·5 frames → `speed` steps 4→5→6→7→8 at each 256-frame boundary, then stays at 8.
- **Collision**:
  - Assert `collision` on the same cycle as `frame_tick` → next cycle `game_over`=1, outputs frozen at their pre-tick values.
  - Keep `start_btn` held high through the death → no restart.
  - Release, then press again → RUN with `scroll_pos`=0, `speed`=4, `score`=0.
- **Saturation and held address**:
  - Preload `score` to 9999 and run 16 frames → `score` stays 0x9999.
  - Hold `match` true for 5 cycles → exactly one `frame_tick`.
